// File: rtl/inst_mem_pipe.sv
module inst_mem_pipe #(
  parameter int    ADDR_W    = 32,
  parameter int    DEPTH_W   = 12,
  parameter int    LATENCY   = 1,
  parameter string INIT_FILE = ""
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic [ADDR_W-1:0] i_req_addr,
  output logic              o_rsp_valid,
  input  logic              i_rsp_ready,
  output logic [31:0]       o_rsp_inst,
  output logic              o_rsp_fault,
  input  logic              i_prog_we,
  input  logic [ADDR_W-1:0] i_prog_addr,
  input  logic [31:0]       i_prog_data
);

  localparam logic [31:0] NOP = 32'h0000_0013;

  function automatic logic addr_bad(input logic [ADDR_W-1:0] a);
    return (a[1:0] != 2'b00) || ((a >> (DEPTH_W + 2)) != '0);
  endfunction

  logic [31:0] mem [2**DEPTH_W];

  logic               stall;
  logic               accept;
  logic               req_bad;
  logic [DEPTH_W-1:0] req_idx;
  logic [DEPTH_W-1:0] prog_idx;

  logic               vld_p1;
  logic [31:0]        inst_p1;
  logic               fault_p1;

  logic               vld_last;
  logic [31:0]        inst_last;
  logic               fault_last;

  assign stall       = vld_last & ~i_rsp_ready;
  assign o_req_ready = ~stall & ~i_prog_we;
  assign accept      = i_req_valid & o_req_ready;
  assign req_bad     = addr_bad(i_req_addr);
  assign req_idx     = i_req_addr[DEPTH_W+1:2];
  assign prog_idx    = i_prog_addr[DEPTH_W+1:2];

  always_ff @(posedge i_clk) begin
    if (i_prog_we && !addr_bad(i_prog_addr))
      mem[prog_idx] <= i_prog_data;
  end

  // ---- stage 1: registered array read ----
  always_ff @(posedge i_clk) begin
    if (i_rst)
      vld_p1 <= 1'b0;
    else if (!stall)
      vld_p1 <= accept;
  end

  always_ff @(posedge i_clk) begin
    if (!stall) begin
      fault_p1 <= req_bad;
      inst_p1  <= req_bad ? NOP : mem[req_idx];
    end
  end

  // ---- stage 2: optional output register ----
  if (LATENCY == 2) begin : g_out_reg
    logic        vld_p2;
    logic [31:0] inst_p2;
    logic        fault_p2;

    always_ff @(posedge i_clk) begin
      if (i_rst)
        vld_p2 <= 1'b0;
      else if (!stall)
        vld_p2 <= vld_p1;
    end

    always_ff @(posedge i_clk) begin
      if (!stall) begin
        inst_p2  <= inst_p1;
        fault_p2 <= fault_p1;
      end
    end

    assign vld_last   = vld_p2;
    assign inst_last  = inst_p2;
    assign fault_last = fault_p2;
  end else begin : g_out_direct
    assign vld_last   = vld_p1;
    assign inst_last  = inst_p1;
    assign fault_last = fault_p1;
  end

  assign o_rsp_valid = vld_last;
  assign o_rsp_inst  = vld_last ? inst_last : 32'h0;
  assign o_rsp_fault = vld_last & fault_last;

endmodule

// File: tb/tb_inst_mem_pipe.sv
// Randomized bench for inst_mem_pipe: LATENCY=1 and LATENCY=2 instances driven
// with the same stimulus, each compared to a queue-style reference model.
module tb_inst_mem_pipe;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        rst, req_valid, rsp_ready, prog_we;
   logic [31:0] req_addr, prog_addr, prog_data;

   logic        ready1, valid1, fault1, ready2, valid2, fault2;
   logic [31:0] inst1, inst2;

   inst_mem_pipe #(.ADDR_W(32), .DEPTH_W(12), .LATENCY(1)) u_l1 (
      .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready1),
      .i_req_addr(req_addr), .o_rsp_valid(valid1), .i_rsp_ready(rsp_ready),
      .o_rsp_inst(inst1), .o_rsp_fault(fault1), .i_prog_we(prog_we),
      .i_prog_addr(prog_addr), .i_prog_data(prog_data));

   inst_mem_pipe #(.ADDR_W(32), .DEPTH_W(12), .LATENCY(2)) u_l2 (
      .i_clk(clk), .i_rst(rst), .i_req_valid(req_valid), .o_req_ready(ready2),
      .i_req_addr(req_addr), .o_rsp_valid(valid2), .i_rsp_ready(rsp_ready),
      .o_rsp_inst(inst2), .o_rsp_fault(fault2), .i_prog_we(prog_we),
      .i_prog_addr(prog_addr), .i_prog_data(prog_data));

   typedef struct packed {
      logic        vld;
      logic [31:0] inst;
      logic        flt;
   } slot_t;

   // pipe[k][j]: in-flight slots of instance k; the response on the outputs is pipe[k][k].
   slot_t       pipe [2][2];
   logic [31:0] ref_mem [4096];
   int          n_cmp = 0;
   int          n_err = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   function automatic bit is_bad(input logic [31:0] a);
      return (a % 4 != 0) || (a >= 32'h0000_4000);
   endfunction

   function automatic logic [31:0] pick_word();
      return ($urandom % 64) * 4;
   endfunction

   task automatic drive(input int cyc);
      int r;
      rst       = 1'b0;
      req_valid = 1'b0;
      req_addr  = 32'h0;
      prog_we   = 1'b0;
      prog_addr = 32'h0;
      prog_data = $urandom;
      rsp_ready = ($urandom % 3) != 0;
      if (cyc < 3) begin
         rst = 1'b1;
         if (cyc == 2) begin
            prog_we   = 1'b1;
            prog_addr = 32'h0000_3FFC;
         end
      end else if (cyc < 67) begin
         prog_we   = 1'b1;
         prog_addr = (cyc - 3) * 4;
      end else begin
         rst       = (cyc % 300) == 150;
         if ((cyc % 64) >= 40 && (cyc % 64) <= 43) rsp_ready = 1'b0;
         prog_we   = ($urandom % 8) == 0;
         r         = $urandom % 10;
         prog_addr = (r < 7) ? pick_word() :
                     (r == 7) ? 32'h0000_3FFC :
                     (r == 8) ? 32'h0000_4000 + pick_word() :
                                pick_word() + 1 + ($urandom % 3);
         req_valid = ($urandom % 4) != 0;
         r         = $urandom % 12;
         req_addr  = (r < 8)  ? pick_word() :
                     (r == 8) ? 32'h0000_3FFC :
                     (r == 9) ? 32'h0000_4000 + pick_word() :
                     (r == 10) ? pick_word() + 1 + ($urandom % 3) :
                                 32'h8000_0000 | pick_word();
      end
   endtask

   initial begin
      slot_t       o;
      slot_t       nxt;
      logic        stl [2];
      logic        acc [2];
      logic        exp_rdy;
      logic [31:0] got_rdy, got_vld, got_inst, got_flt;
      string       nm;

      for (int k = 0; k < 2; k++)
         for (int j = 0; j < 2; j++)
            pipe[k][j] = '0;
      rst       = 1'b1;
      req_valid = 1'b0;
      req_addr  = 32'h0;
      rsp_ready = 1'b1;
      prog_we   = 1'b0;
      prog_addr = 32'h0;
      prog_data = 32'h0;

      for (int cyc = 0; cyc < 2500; cyc++) begin
         @(negedge clk);
         drive(cyc);
         #1;
         for (int k = 0; k < 2; k++) begin
            o       = pipe[k][k];
            stl[k]  = o.vld & ~rsp_ready;
            exp_rdy = ~stl[k] & ~prog_we;
            acc[k]  = req_valid & exp_rdy;
            nm      = (k == 0) ? "L1" : "L2";
            got_rdy  = {31'b0, (k == 0) ? ready1 : ready2};
            got_vld  = {31'b0, (k == 0) ? valid1 : valid2};
            got_flt  = {31'b0, (k == 0) ? fault1 : fault2};
            got_inst = (k == 0) ? inst1 : inst2;
            check({nm, " req_ready"}, got_rdy, {31'b0, exp_rdy});
            check({nm, " rsp_valid"}, got_vld, {31'b0, o.vld});
            check({nm, " rsp_inst"}, got_inst, o.vld ? o.inst : 32'h0);
            check({nm, " rsp_fault"}, got_flt, {31'b0, o.vld & o.flt});
         end
         for (int k = 0; k < 2; k++) begin
            if (rst) begin
               pipe[k][0] = '0;
               pipe[k][1] = '0;
            end else if (!stl[k]) begin
               nxt = '0;
               if (acc[k]) begin
                  nxt.vld  = 1'b1;
                  nxt.flt  = is_bad(req_addr);
                  nxt.inst = nxt.flt ? 32'h0000_0013 : ref_mem[(req_addr / 4) % 4096];
               end
               pipe[k][1] = pipe[k][0];
               pipe[k][0] = nxt;
            end
         end
         if (prog_we && !is_bad(prog_addr))
            ref_mem[prog_addr / 4] = prog_data;
      end

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
